// File: rtl/serial_frame_rx.sv
// Serial-to-parallel frame receiver with a one-word valid/ready output buffer.
// state | meaning:  IDLE | waiting for a start strobe;  SHIFT | frame bits arriving
module serial_frame_rx #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enb,
  input  logic          start,
  input  logic          sdi,
  input  logic          msb_first,
  input  logic          ready,
  input  logic          clr,
  output logic [DW-1:0] data,
  output logic          valid,
  output logic          busy,
  output logic          overrun,
  output logic          frame_err
);

  localparam int CW = (DW > 2) ? $clog2(DW) : 1;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   sreg_q, sreg_d;
  logic            msb_q, msb_d;
  logic [DW-1:0]   data_q, data_d;
  logic            valid_q, valid_d;
  logic            ovr_q, ovr_d;
  logic            ferr_q, ferr_d;

  logic            frame_start;
  logic            mid_restart;
  logic            frame_done;
  logic            accept;
  logic [DW-1:0]   word_done;

  function automatic logic [DW-1:0] ins(input logic [DW-1:0] s, input logic b,
                                        input logic m);
    return m ? {s[DW-2:0], b} : {b, s[DW-1:1]};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      msb_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      msb_q   <= msb_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    frame_start = enb && start;
    mid_restart = enb && start && (state_q == SHIFT);
    frame_done  = enb && !start && (state_q == SHIFT) && (cnt_q == CW'(DW - 1));
    state_d     = state_q;
    if (frame_start)     state_d = SHIFT;
    else if (frame_done) state_d = IDLE;
  end

  always_comb begin
    cnt_d     = cnt_q;
    sreg_d    = sreg_q;
    msb_d     = msb_q;
    word_done = ins(sreg_q, sdi, msb_q);
    accept    = valid_q && ready;
    data_d    = data_q;
    valid_d   = valid_q;
    ovr_d     = clr ? 1'b0 : ovr_q;
    ferr_d    = clr ? 1'b0 : ferr_q;

    // Every frame shifts in DW fresh bits, so stale register contents never leak.
    if (frame_start) begin
      msb_d  = msb_first;
      sreg_d = ins(sreg_q, sdi, msb_first);
      cnt_d  = CW'(1);
    end else if (enb && state_q == SHIFT) begin
      sreg_d = word_done;
      cnt_d  = frame_done ? '0 : cnt_q + CW'(1);
    end

    if (mid_restart) ferr_d = 1'b1;

    if (frame_done) begin
      if (!valid_q || accept) begin
        data_d  = word_done;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    busy      = (state_q == SHIFT);
    data      = data_q;
    valid     = valid_q;
    overrun   = ovr_q;
    frame_err = ferr_q;
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: a frame-level reference model checked every cycle,
// plus hand-computed expectations for the key scenarios.
module tb_serial_frame_rx;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enb = 1'b0;
  logic          start = 1'b0;
  logic          sdi = 1'b0;
  logic          msb_first = 1'b1;
  logic          ready = 1'b0;
  logic          clr = 1'b0;
  logic [DW-1:0] data;
  logic          valid, busy, overrun, frame_err;

  int n_tests = 0;
  int n_fail  = 0;

  serial_frame_rx #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .enb(enb), .start(start), .sdi(sdi),
    .msb_first(msb_first), .ready(ready), .clr(clr),
    .data(data), .valid(valid), .busy(busy), .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Reference model: collects the frame's bits in arrival order, builds the word at the end.
  bit          m_bits [DW];
  int          m_cnt;
  bit          m_in_frame;
  bit          m_msb;
  bit [DW-1:0] m_data;
  bit          m_valid, m_ovr, m_ferr;

  always @(posedge clk or negedge rst) begin
    bit          done;
    bit          acc;
    bit [DW-1:0] w;
    if (!rst) begin
      m_cnt = 0; m_in_frame = 0; m_msb = 0;
      m_data = '0; m_valid = 0; m_ovr = 0; m_ferr = 0;
    end else begin
      done = 0;
      acc  = m_valid && ready;
      if (clr) begin m_ovr = 0; m_ferr = 0; end
      if (enb && start) begin
        if (m_in_frame) m_ferr = 1;
        m_in_frame = 1;
        m_msb      = msb_first;
        m_bits[0]  = sdi;
        m_cnt      = 1;
      end else if (enb && m_in_frame) begin
        m_bits[m_cnt] = sdi;
        m_cnt++;
        if (m_cnt == DW) begin
          done = 1;
          m_in_frame = 0;
          m_cnt = 0;
        end
      end
      if (done) begin
        w = '0;
        for (int i = 0; i < DW; i++) begin
          if (m_msb) w[DW-1-i] = m_bits[i];
          else       w[i]      = m_bits[i];
        end
        if (!m_valid || acc) begin m_data = w; m_valid = 1; end
        else m_ovr = 1;
      end else if (acc) begin
        m_valid = 0;
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cmp("model_data",  int'(data),      int'(m_data));
    cmp("model_valid", int'(valid),     int'(m_valid));
    cmp("model_busy",  int'(busy),      int'(m_in_frame));
    cmp("model_ovr",   int'(overrun),   int'(m_ovr));
    cmp("model_ferr",  int'(frame_err), int'(m_ferr));
  end

  // Inputs change on the falling edge; the next rising edge samples them.
  task automatic drive(input logic st, input logic d, input logic en,
                       input logic rdy, input logic cl);
    @(negedge clk);
    start = st; sdi = d; enb = en; ready = rdy; clr = cl;
  endtask

  task automatic frame(input logic [DW-1:0] bits, input logic rdy_last, input logic rdy);
    for (int i = 0; i < DW; i++)
      drive(i == 0, bits[DW-1-i], 1'b1, (i == DW-1) ? rdy_last : rdy, 1'b0);
  endtask

  initial begin
    #12;
    cmp("reset_data",  int'(data), 0);
    cmp("reset_valid", int'(valid), 0);
    cmp("reset_busy",  int'(busy), 0);
    cmp("reset_flags", int'({overrun, frame_err}), 0);
    @(negedge clk); rst = 1'b1;

    // 1: msb first, sdi 1,0,1,1
    msb_first = 1'b1;
    drive(1, 1, 1, 1, 0);
    drive(0, 0, 1, 1, 0);
    cmp("t1_busy_mid", int'(busy), 1);
    drive(0, 1, 1, 1, 0);
    drive(0, 1, 1, 1, 0);
    drive(0, 0, 0, 1, 0);
    cmp("t1_data", int'(data), 'b1011);
    cmp("t1_valid", int'(valid), 1);
    cmp("t1_busy_done", int'(busy), 0);
    drive(0, 0, 0, 1, 0);
    cmp("t1_valid_drop", int'(valid), 0);

    // 2: lsb first with an enb=0 gap (start/sdi garbage ignored)
    msb_first = 1'b0;
    drive(1, 1, 1, 1, 0);
    drive(0, 0, 1, 1, 0);
    drive(1, 1, 0, 1, 0);
    drive(0, 1, 1, 1, 0);
    msb_first = 1'b1;
    drive(0, 1, 1, 1, 0);
    drive(0, 0, 0, 1, 0);
    cmp("t2_data", int'(data), 'b1101);
    cmp("t2_ferr", int'(frame_err), 0);

    // 3: overrun on back-to-back frames with ready low
    msb_first = 1'b1;
    drive(0, 0, 0, 0, 0);
    frame(4'hA, 0, 0);
    frame(4'h5, 0, 0);
    drive(0, 0, 0, 1, 0);
    cmp("t3_data_kept", int'(data), 'hA);
    cmp("t3_valid", int'(valid), 1);
    cmp("t3_ovr", int'(overrun), 1);
    drive(0, 0, 0, 0, 1);
    cmp("t3_valid_drop", int'(valid), 0);
    drive(0, 0, 0, 0, 0);
    cmp("t3_ovr_clr", int'(overrun), 0);

    // 4: completion coincides with consumption
    frame(4'hA, 0, 0);
    frame(4'h3, 1, 0);
    drive(0, 0, 0, 0, 0);
    cmp("t4_data", int'(data), 'h3);
    cmp("t4_valid", int'(valid), 1);
    cmp("t4_ovr", int'(overrun), 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    cmp("t4_valid_drop", int'(valid), 0);

    // 5: mid-frame restart (with clr in the same cycle), then async reset mid-frame
    drive(1, 1, 1, 1, 0);
    drive(0, 1, 1, 1, 0);
    drive(1, 0, 1, 1, 1);
    drive(0, 1, 1, 1, 0);
    drive(0, 1, 1, 1, 0);
    drive(0, 0, 1, 1, 0);
    drive(0, 0, 0, 1, 0);
    cmp("t5_ferr", int'(frame_err), 1);
    cmp("t5_data", int'(data), 'b0110);
    drive(1, 1, 1, 0, 0);
    drive(0, 1, 1, 0, 0);
    #2 rst = 1'b0;
    #1;
    cmp("t5_rst_busy", int'(busy), 0);
    cmp("t5_rst_data", int'(data), 0);
    cmp("t5_rst_flags", int'({valid, overrun, frame_err}), 0);
    @(posedge clk); #2 rst = 1'b1;
    drive(0, 1, 1, 1, 0);
    drive(0, 0, 1, 1, 0);
    drive(0, 0, 0, 1, 0);
    cmp("t5_no_valid", int'(valid), 0);
    cmp("t5_idle", int'(busy), 0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
